// File: rtl/gelu_int8_vec_if.sv
// Stream bundle for the int8 GELU vector block: input beat with scales, output beat,
// and the valid/ready pair on each side.
interface gelu_int8_vec_if #(
  parameter int LANES = 32,
  parameter int DW    = 8
);
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [15:0]           in_scale;
  logic [15:0]           out_scale;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [LANES*DW-1:0]   out_data;

  modport master (
    output data_in_valid, in_data, in_scale, out_scale, data_out_ready,
    input  data_in_ready, data_out_valid, out_data
  );

  modport slave (
    input  data_in_valid, in_data, in_scale, out_scale, data_out_ready,
    output data_in_ready, data_out_valid, out_data
  );
endinterface

// File: rtl/gelu_int8_vec.sv
// 32-lane int8 GELU using the I-BERT second-order erf polynomial in Q.16,
// three register stages with a single global advance enable.
module gelu_int8_vec #(
  parameter int LANES = 32,
  parameter int DW    = 8
) (
  input logic             clk,
  input logic             rst,
  gelu_int8_vec_if.slave  bus
);

  localparam logic [23:0] U_CLIP = 24'd115934;

  logic en;
  assign en = !bus.data_out_valid || bus.data_out_ready;
  assign bus.data_in_ready = en;

  logic                s1_valid, s2_valid, s3_valid;
  logic [15:0]         s1_os, s2_os;
  logic signed [23:0]  s1_x [LANES];
  logic [23:0]         s1_u [LANES];
  logic signed [23:0]  s2_x [LANES];
  logic signed [17:0]  s2_e [LANES];
  logic [LANES*DW-1:0] s3_data;

  logic signed [23:0]  x_c  [LANES];
  logic [23:0]         u_c  [LANES];
  logic signed [17:0]  e_c  [LANES];
  logic [LANES*DW-1:0] y_c;

  assign bus.data_out_valid = s3_valid;
  assign bus.out_data       = s3_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0] q;
    logic signed [24:0]   x_full;
    logic [23:0]          a;
    logic [39:0]          ua;
    logic [16:0]          c;
    logic signed [17:0]   d;
    logic signed [35:0]   dd;
    logic [17:0]          d2;
    logic [32:0]          pp;
    logic [16:0]          p;
    logic [16:0]          l;
    logic signed [18:0]   f;
    logic signed [42:0]   gp;
    logic signed [23:0]   g;
    logic signed [41:0]   rp;
    logic signed [21:0]   r;

    // S1: dequantize and scale |x| by 1/sqrt2
    assign q      = bus.in_data[i*DW +: DW];
    assign x_full = 25'(q) * $signed({9'd0, bus.in_scale});
    assign x_c[i] = 24'(x_full);
    assign a      = x_c[i][23] ? 24'(-x_c[i]) : 24'(x_c[i]);
    assign ua     = 40'(a) * 40'd46341;
    assign u_c[i] = 24'(ua >> 16);

    // S2: clipped polynomial gives L = erf(|x|/sqrt2); sign restored from x
    assign c      = (s1_u[i] >= U_CLIP) ? 17'd115934 : 17'(s1_u[i]);
    assign d      = $signed({1'b0, c}) - 18'sd115934;
    assign dd     = 36'(d) * 36'(d);
    assign d2     = 18'(dd >>> 16);
    assign pp     = 33'(d2) * 33'd18927;
    assign p      = 17'(pp >> 16);
    assign l      = 17'd65536 - p;
    assign e_c[i] = s1_x[i][23] ? -$signed({1'b0, l}) : $signed({1'b0, l});

    // S3: g = x*(1+erf)/2, then requantize with round-half-up and clamp
    assign f  = 19'sd65536 + 19'(s2_e[i]);
    assign gp = 43'(s2_x[i]) * 43'(f);
    assign g  = 24'(gp >>> 17);
    assign rp = 42'(g) * $signed({26'd0, s2_os}) + 42'sd524288;
    assign r  = 22'(rp >>> 20);
    assign y_c[i*DW +: DW] = (r > 22'sd127)  ? 8'sd127 :
                             (r < -22'sd128) ? -8'sd128 : DW'(r);
  end

  // All stages move together; out_data only loads on a real beat so bubbles keep the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_os    <= '0;
      s2_os    <= '0;
      s3_data  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_x[i] <= '0;
        s1_u[i] <= '0;
        s2_x[i] <= '0;
        s2_e[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= bus.data_in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_os    <= bus.out_scale;
      s2_os    <= s1_os;
      for (int i = 0; i < LANES; i++) begin
        s1_x[i] <= x_c[i];
        s1_u[i] <= u_c[i];
        s2_x[i] <= s1_x[i];
        s2_e[i] <= e_c[i];
      end
      if (s2_valid) s3_data <= y_c;
    end
  end

endmodule

// File: tb/tb_gelu_int8_vec.sv
// Directed bench for gelu_int8_vec: hand-computed lane values plus a small
// integer model of the GELU arithmetic for the streaming scenarios.
module tb_gelu_int8_vec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gelu_int8_vec_if #(.LANES(32), .DW(8)) bus();

  gelu_int8_vec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [255:0] beat_data [64];
  logic [15:0]  beat_is   [64];
  logic [15:0]  beat_os   [64];
  logic [255:0] res_data  [64];
  int           res_cycle [64];
  int           res_count;

  function automatic int gelu_ref(input int q, input int is, input int os);
    longint x, a, u, c, d, d2, p, l, e, g, r;
    x  = longint'(q) * longint'(is);
    a  = (x < 0) ? -x : x;
    u  = (a * 46341) >>> 16;
    c  = (u < 115934) ? u : 115934;
    d  = c - 115934;
    d2 = (d * d) >>> 16;
    p  = (d2 * 18927) >>> 16;
    l  = 65536 - p;
    e  = (x < 0) ? -l : l;
    g  = (x * (65536 + e)) >>> 17;
    r  = (g * longint'(os) + 524288) >>> 20;
    if (r > 127) return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  function automatic logic [255:0] model_vec(input logic [255:0] d, input int is, input int os);
    logic [255:0]       v;
    logic signed [7:0]  qb;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      qb = d[i*8 +: 8];
      v[i*8 +: 8] = 8'(gelu_ref(int'(qb), is, os));
    end
    return v;
  endfunction

  function automatic logic [255:0] nominal_beat();
    logic [255:0] d;
    d = '0;
    d[0*8 +: 8] = 8'd30;
    d[1*8 +: 8] = 8'd25;
    d[2*8 +: 8] = 8'd24;
    d[3*8 +: 8] = 8'hF9;
    d[4*8 +: 8] = 8'd51;
    return d;
  endfunction

  // Drives beat_data[0..nbeats-1] with an optional consumer stall window and collects outputs
  task automatic run_stream(input int nbeats, input int stall_start, input int stall_len,
                            output int viol, output int stall_cycles);
    int           sent;
    logic         prev_stall;
    logic [255:0] prev_data;
    sent = 0;
    res_count = 0;
    viol = 0;
    stall_cycles = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 200 && res_count < nbeats; cyc++) begin
      bus.data_out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      if (sent < nbeats) begin
        bus.data_in_valid = 1'b1;
        bus.in_data       = beat_data[sent];
        bus.in_scale      = beat_is[sent];
        bus.out_scale     = beat_os[sent];
      end else begin
        bus.data_in_valid = 1'b0;
      end
      #1;
      if (prev_stall && (bus.out_data !== prev_data || bus.data_out_valid !== 1'b1)) viol++;
      if (bus.data_out_valid && !bus.data_out_ready) begin
        stall_cycles++;
        if (bus.data_in_ready !== 1'b0) viol++;
      end
      if (bus.data_in_valid && bus.data_in_ready) sent++;
      if (bus.data_out_valid && bus.data_out_ready) begin
        res_data[res_count]  = bus.out_data;
        res_cycle[res_count] = cyc;
        res_count++;
      end
      prev_stall = bus.data_out_valid && !bus.data_out_ready;
      prev_data  = bus.out_data;
      @(posedge clk);
      #1;
    end
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    bus.in_data   = '0;
    bus.in_scale  = '0;
    bus.out_scale = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.data_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.data_out_valid);
    else passes++;
    checks++;
    if (bus.out_data !== 256'd0) $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data);
    else passes++;
    checks++;
    if (bus.data_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.data_in_ready);
    else passes++;
  endtask

  task automatic test_nominal;
    logic [255:0] exp_zero_mask;
    logic [7:0]   lane2_exp;
    bus.data_out_ready = 1'b1;
    bus.in_data   = nominal_beat();
    bus.in_scale  = 16'd2005;
    bus.out_scale = 16'd1072;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    checks++;
    if (bus.data_out_valid !== 1'b0) $display("[TB] FAIL nominal_latency_k: got %b expected 0", bus.data_out_valid);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out_valid !== 1'b0) $display("[TB] FAIL nominal_latency_k1: got %b expected 0", bus.data_out_valid);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out_valid !== 1'b1) $display("[TB] FAIL nominal_latency_k2: got %b expected 1", bus.data_out_valid);
    else passes++;
    checks++;
    if ($signed(bus.out_data[0*8 +: 8]) !== 8'sd50) $display("[TB] FAIL nominal_lane0: got %0d expected 50", $signed(bus.out_data[0*8 +: 8]));
    else passes++;
    checks++;
    if ($signed(bus.out_data[1*8 +: 8]) !== 8'sd40) $display("[TB] FAIL nominal_lane1: got %0d expected 40", $signed(bus.out_data[1*8 +: 8]));
    else passes++;
    lane2_exp = 8'(gelu_ref(24, 2005, 1072));
    checks++;
    if (bus.out_data[2*8 +: 8] !== lane2_exp) $display("[TB] FAIL nominal_lane2: got %0d expected %0d", $signed(bus.out_data[2*8 +: 8]), $signed(lane2_exp));
    else passes++;
    checks++;
    if ($signed(bus.out_data[3*8 +: 8]) !== -8'sd5) $display("[TB] FAIL nominal_lane3: got %0d expected -5", $signed(bus.out_data[3*8 +: 8]));
    else passes++;
    checks++;
    if ($signed(bus.out_data[4*8 +: 8]) !== 8'sd98) $display("[TB] FAIL nominal_lane4: got %0d expected 98", $signed(bus.out_data[4*8 +: 8]));
    else passes++;
    exp_zero_mask = {{216{1'b1}}, 40'd0};
    checks++;
    if ((bus.out_data & exp_zero_mask) !== 256'd0) $display("[TB] FAIL nominal_zero_lanes: got %h expected 0", bus.out_data & exp_zero_mask);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation;
    int viol, stalls;
    beat_data[0] = '0;
    beat_data[0][0*8 +: 8] = 8'd127;
    beat_data[0][1*8 +: 8] = 8'h80;
    beat_is[0] = 16'd65535;
    beat_os[0] = 16'd1072;
    beat_data[1] = '0;
    beat_data[1][0*8 +: 8] = 8'hFF;
    beat_data[1][1*8 +: 8] = 8'd1;
    beat_is[1] = 16'd65535;
    beat_os[1] = 16'd65535;
    run_stream(2, 1000, 0, viol, stalls);
    checks++;
    if (res_count !== 2) $display("[TB] FAIL sat_count: got %0d expected 2", res_count);
    else passes++;
    checks++;
    if ($signed(res_data[0][0*8 +: 8]) !== 8'sd127) $display("[TB] FAIL sat_pos127: got %0d expected 127", $signed(res_data[0][0*8 +: 8]));
    else passes++;
    checks++;
    if ($signed(res_data[0][1*8 +: 8]) !== 8'sd0) $display("[TB] FAIL sat_neg128: got %0d expected 0", $signed(res_data[0][1*8 +: 8]));
    else passes++;
    checks++;
    if ($signed(res_data[1][0*8 +: 8]) !== -8'sd128) $display("[TB] FAIL sat_low_rail: got %0d expected -128", $signed(res_data[1][0*8 +: 8]));
    else passes++;
    checks++;
    if ($signed(res_data[1][1*8 +: 8]) !== 8'sd127) $display("[TB] FAIL sat_high_rail: got %0d expected 127", $signed(res_data[1][1*8 +: 8]));
    else passes++;
  endtask

  task automatic test_backpressure;
    int viol, stalls;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 32; i++) beat_data[b][i*8 +: 8] = 8'(b * 41 + i * 13 - 60);
      beat_is[b] = 16'(1500 + b * 700);
      beat_os[b] = 16'(900 + b * 150);
    end
    run_stream(4, 3, 3, viol, stalls);
    checks++;
    if (res_count !== 4) $display("[TB] FAIL bp_count: got %0d expected 4", res_count);
    else passes++;
    checks++;
    if (viol !== 0) $display("[TB] FAIL bp_stall_hold: got %0d violations expected 0", viol);
    else passes++;
    checks++;
    if (stalls !== 3) $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stalls);
    else passes++;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (res_data[b] !== model_vec(beat_data[b], int'(beat_is[b]), int'(beat_os[b])))
        $display("[TB] FAIL bp_beat%0d: got %h expected %h", b, res_data[b],
                 model_vec(beat_data[b], int'(beat_is[b]), int'(beat_os[b])));
      else passes++;
    end
  endtask

  task automatic test_scale_per_beat;
    int viol, stalls;
    beat_data[0] = nominal_beat();
    beat_is[0]   = 16'd2005;
    beat_os[0]   = 16'd1072;
    beat_data[1] = nominal_beat();
    beat_is[1]   = 16'd0;
    beat_os[1]   = 16'd1072;
    run_stream(2, 1000, 0, viol, stalls);
    checks++;
    if (res_count !== 2) $display("[TB] FAIL scale_count: got %0d expected 2", res_count);
    else passes++;
    checks++;
    if (res_data[0][39:0] !== {8'd98, 8'hFB, 8'(gelu_ref(24, 2005, 1072)), 8'd40, 8'd50})
      $display("[TB] FAIL scale_beat_a: got %h expected lanes 50,40,m,-5,98", res_data[0][39:0]);
    else passes++;
    checks++;
    if (res_data[1] !== 256'd0) $display("[TB] FAIL scale_beat_b: got %h expected 0", res_data[1]);
    else passes++;
  endtask

  task automatic test_reset_midflight;
    logic seen;
    bus.data_out_ready = 1'b1;
    bus.in_scale  = 16'd2005;
    bus.out_scale = 16'd1072;
    bus.in_data   = nominal_beat();
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data = ~nominal_beat();
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.data_out_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", bus.data_out_valid);
    else passes++;
    checks++;
    if (bus.out_data !== 256'd0) $display("[TB] FAIL midrst_data: got %h expected 0", bus.out_data);
    else passes++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.data_out_valid === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL midrst_stale: got %b expected 0", seen);
    else passes++;
    bus.in_data = nominal_beat();
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out_valid !== 1'b0) $display("[TB] FAIL midrst_early: got %b expected 0", bus.data_out_valid);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.data_out_valid !== 1'b1 || $signed(bus.out_data[7:0]) !== 8'sd50)
      $display("[TB] FAIL midrst_new_beat: got valid=%b lane0=%0d expected valid=1 lane0=50",
               bus.data_out_valid, $signed(bus.out_data[7:0]));
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_throughput;
    int viol, stalls;
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 32; i++) beat_data[b][i*8 +: 8] = 8'(b * 53 + i * 29 + 7);
      beat_is[b] = 16'(500 + b * 1900);
      beat_os[b] = 16'(300 + b * 97);
    end
    run_stream(32, 1000, 0, viol, stalls);
    checks++;
    if (res_count !== 32) $display("[TB] FAIL thr_count: got %0d expected 32", res_count);
    else passes++;
    checks++;
    if (res_cycle[31] - res_cycle[0] !== 31) $display("[TB] FAIL thr_bubbles: got span %0d expected 31", res_cycle[31] - res_cycle[0]);
    else passes++;
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (res_data[b] !== model_vec(beat_data[b], int'(beat_is[b]), int'(beat_os[b])))
        $display("[TB] FAIL thr_beat%0d: got %h expected %h", b, res_data[b],
                 model_vec(beat_data[b], int'(beat_is[b]), int'(beat_os[b])));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_backpressure();
    test_scale_per_beat();
    test_reset_midflight();
    test_full_throughput();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
